fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS pipeline; sits directly upstream of the instruction memory (imem).
- Owns the program counter and drives imem's 6-bit word index, then captures imem's combinational read data into the IF/ID pipeline register.
- Applies stall, flush and redirect (branch/jump) control from later stages.
- Counts retired fetches for debug.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fetch_stage_if.sv | 43 ++++
 rtl/fetch_stage_pc_next.sv | 55 +++++
 rtl/fetch_stage.sv | 71 +++++++
 tb/tb_fetch_stage.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Used by the fetch stage and its next-PC logic.
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int JIDX_W = 26;

    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_JUMP,
        SEL_BRANCH
    } pc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: hazard/redirect control, imem port, IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline/imem.
interface fetch_stage_if
    import mips_pkg::*;
#(
    parameter int IMEM_AW = 6
);
    logic               stall_i;
    logic               flush_i;
    logic               branch_taken_i;
    logic [XLEN-1:0]    branch_target_i;
    logic               jump_i;
    logic [JIDX_W-1:0]  jump_index_i;
    logic [IMEM_AW-1:0] imem_addr_o;
    logic [XLEN-1:0]    imem_rd_i;
    logic [XLEN-1:0]    pc_o;
    logic [XLEN-1:0]    pcplus4_o;
    logic [XLEN-1:0]    instr_o;
    logic               valid_o;
    logic               misalign_o;
    logic [XLEN-1:0]    fetch_count_o;

    modport master (
        input  stall_i, flush_i,
        input  branch_taken_i, branch_target_i,
        input  jump_i, jump_index_i,
        input  imem_rd_i,
        output imem_addr_o,
        output pc_o, pcplus4_o, instr_o, valid_o,
        output misalign_o, fetch_count_o
    );

    modport slave (
        output stall_i, flush_i,
        output branch_taken_i, branch_target_i,
        output jump_i, jump_index_i,
        output imem_rd_i,
        input  imem_addr_o,
        input  pc_o, pcplus4_o, instr_o, valid_o,
        input  misalign_o, fetch_count_o
    );

endinterface

// File: rtl/fetch_stage_pc_next.sv
// Combinational next-PC select for the fetch stage.
// Branch (older, from EX) beats jump (ID) beats stall beats PC+4.
module pc_next
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   id_pcplus4,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_target,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    output logic [XLEN-1:0]   next_pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              redirect,
    output logic              misalign
);
    pc_sel_e         sel;
    logic [XLEN-1:0] jump_target;

    assign pc_plus4    = pc + 32'd4;
    assign jump_target = {id_pcplus4[31:28], jump_index, 2'b00};

    // Priority-encode the PC source.
    always_comb begin
        sel = SEL_SEQ;
        priority case (1'b1)
            branch_taken: sel = SEL_BRANCH;
            jump:         sel = SEL_JUMP;
            stall:        sel = SEL_HOLD;
            default:      sel = SEL_SEQ;
        endcase
    end

    // Mux the PC and flag redirects; jump targets are aligned by construction.
    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b0;
        misalign = 1'b0;
        unique case (sel)
            SEL_BRANCH: begin
                next_pc  = {branch_target[31:2], 2'b00};
                redirect = 1'b1;
                misalign = |branch_target[1:0];
            end
            SEL_JUMP: begin
                next_pc  = jump_target;
                redirect = 1'b1;
            end
            SEL_HOLD: next_pc = pc;
            default:  next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem addressing, IF/ID register.
// imem is combinational, so each fetch completes in one cycle.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int              IMEM_AW  = 6
) (
    input logic           clk,
    input logic           reset,
    fetch_stage_if.master bus
);
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] fetch_cnt;
    logic            redirect;
    logic            misal_nxt;
    logic            misalign;
    if_id_t          if_id;

    pc_next u_pc_next (
        .pc            (pc),
        .id_pcplus4    (if_id.pcplus4),
        .stall         (bus.stall_i),
        .branch_taken  (bus.branch_taken_i),
        .branch_target (bus.branch_target_i),
        .jump          (bus.jump_i),
        .jump_index    (bus.jump_index_i),
        .next_pc       (pc_nxt),
        .pc_plus4      (pc_plus4),
        .redirect      (redirect),
        .misalign      (misal_nxt)
    );

    assign bus.imem_addr_o   = pc[IMEM_AW+1:2];
    assign bus.pc_o          = if_id.pc;
    assign bus.pcplus4_o     = if_id.pcplus4;
    assign bus.instr_o       = if_id.instr;
    assign bus.valid_o       = if_id.valid;
    assign bus.misalign_o    = misalign;
    assign bus.fetch_count_o = fetch_cnt;

    // PC, IF/ID latch with flush/redirect bubbles, sticky misalign, counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            if_id     <= '0;
            fetch_cnt <= '0;
            misalign  <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (misal_nxt) begin
                misalign <= 1'b1;
            end
            if (bus.flush_i || redirect) begin
                if_id.instr <= NOP_INSTR;
                if_id.valid <= 1'b0;
            end else if (!bus.stall_i) begin
                if_id <= '{
                    pc:      pc,
                    pcplus4: pc_plus4,
                    instr:   bus.imem_rd_i,
                    valid:   1'b1
                };
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a behavioural model.
// Directed scenarios plus randomized control traffic.
module tb_fetch_stage;

    logic clk;
    logic reset;
    logic reset2;
    logic [31:0] imem [64];

    int checks = 0;
    int errors = 0;

    fetch_stage_if #(.IMEM_AW(6)) bus ();
    fetch_stage_if #(.IMEM_AW(6)) bus2 ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(6)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    assign bus.imem_rd_i  = imem[bus.imem_addr_o];
    assign bus2.imem_rd_i = imem[bus2.imem_addr_o];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state (main DUT, RESET_PC = 0).
    logic [31:0] m_pc, m_pco, m_p4, m_instr, m_cnt;
    logic        m_valid, m_mis;

    // Advance one clock edge, update model from the rules, settle 1ns.
    task automatic tick();
        logic [31:0] tgt;
        logic [31:0] npc;
        logic        redir;
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h0; m_pco = 0; m_p4 = 0; m_instr = 0;
            m_cnt = 0; m_valid = 0; m_mis = 0;
        end else begin
            redir = bus.branch_taken_i || bus.jump_i;
            tgt = 0;
            if (bus.branch_taken_i)
                tgt = bus.branch_target_i;
            else if (bus.jump_i)
                tgt = (m_p4 & 32'hF000_0000) + (32'(bus.jump_index_i) * 4);
            if (redir) begin
                if (tgt % 4 != 0) m_mis = 1;
                npc = tgt - (tgt % 4);
            end else if (bus.stall_i) begin
                npc = m_pc;
            end else begin
                npc = m_pc + 4;
            end
            if (bus.flush_i || redir) begin
                m_instr = 0;
                m_valid = 0;
            end else if (!bus.stall_i) begin
                m_pco = m_pc;
                m_p4 = m_pc + 4;
                m_instr = imem[(m_pc / 4) % 64];
                m_valid = 1;
                m_cnt = m_cnt + 1;
            end
            m_pc = npc;
        end
        #1;
    endtask

    task automatic clear_ctrl();
        bus.stall_i = 0;
        bus.flush_i = 0;
        bus.branch_taken_i = 0;
        bus.branch_target_i = 0;
        bus.jump_i = 0;
        bus.jump_index_i = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) imem[i] = $urandom;
        imem[0] = 32'h2001_0007;
        imem[1] = 32'h2002_0008;
        clear_ctrl();
        bus2.stall_i = 0; bus2.flush_i = 0;
        bus2.branch_taken_i = 0; bus2.branch_target_i = 0;
        bus2.jump_i = 0; bus2.jump_index_i = 0;
        reset = 1; reset2 = 1;
        tick(); tick();
        checks++;
        if (bus.pc_o !== 0 || bus.pcplus4_o !== 0 || bus.instr_o !== 0) begin
            errors++;
            $display("FAIL reset_ifid got %h/%h/%h want 0", bus.pc_o, bus.pcplus4_o, bus.instr_o);
        end
        checks++;
        if (bus.valid_o !== 0 || bus.misalign_o !== 0 || bus.fetch_count_o !== 0) begin
            errors++;
            $display("FAIL reset_flags got v%b m%b c%0d want 0", bus.valid_o, bus.misalign_o, bus.fetch_count_o);
        end
        checks++;
        if (bus.imem_addr_o !== 6'd0) begin
            errors++;
            $display("FAIL reset_addr got %0d want 0", bus.imem_addr_o);
        end
    endtask

    task automatic test_freerun();
        reset = 0;
        tick();
        checks++;
        if (bus.instr_o !== 32'h2001_0007 || bus.pc_o !== 0 || bus.valid_o !== 1) begin
            errors++;
            $display("FAIL free1 got i%h pc%h v%b want 20010007/0/1", bus.instr_o, bus.pc_o, bus.valid_o);
        end
        tick();
        checks++;
        if (bus.instr_o !== 32'h2002_0008 || bus.pc_o !== 4 || bus.pcplus4_o !== 8) begin
            errors++;
            $display("FAIL free2 got i%h pc%h p4%h want 20020008/4/8", bus.instr_o, bus.pc_o, bus.pcplus4_o);
        end
        checks++;
        if (bus.fetch_count_o !== 2) begin
            errors++;
            $display("FAIL free_cnt got %0d want 2", bus.fetch_count_o);
        end
    endtask

    task automatic test_stall();
        bus.stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.imem_addr_o !== 6'd2 || bus.pc_o !== 4 || bus.instr_o !== 32'h2002_0008) begin
                errors++;
                $display("FAIL stall_hold got a%0d pc%h i%h want 2/4/20020008", bus.imem_addr_o, bus.pc_o, bus.instr_o);
            end
            checks++;
            if (bus.fetch_count_o !== 2) begin
                errors++;
                $display("FAIL stall_cnt got %0d want 2", bus.fetch_count_o);
            end
        end
        bus.stall_i = 0;
        tick();
        checks++;
        if (bus.pc_o !== 8 || bus.instr_o !== imem[2] || bus.valid_o !== 1 || bus.fetch_count_o !== 3) begin
            errors++;
            $display("FAIL stall_resume got pc%h i%h c%0d want 8/%h/3", bus.pc_o, bus.instr_o, bus.fetch_count_o, imem[2]);
        end
    endtask

    task automatic test_branch();
        bus.branch_taken_i = 1;
        bus.branch_target_i = 32'h38;
        tick();
        clear_ctrl();
        checks++;
        if (bus.imem_addr_o !== 6'd14 || bus.valid_o !== 0 || bus.instr_o !== 0) begin
            errors++;
            $display("FAIL branch_bubble got a%0d v%b i%h want 14/0/0", bus.imem_addr_o, bus.valid_o, bus.instr_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 32'h38 || bus.valid_o !== 1 || bus.instr_o !== imem[14]) begin
            errors++;
            $display("FAIL branch_target got pc%h v%b i%h want 38/1/%h", bus.pc_o, bus.valid_o, bus.instr_o, imem[14]);
        end
    endtask

    task automatic test_jump();
        bus.branch_taken_i = 1;
        bus.branch_target_i = 32'hC;
        tick();
        clear_ctrl();
        tick();
        checks++;
        if (bus.pcplus4_o !== 32'h10) begin
            errors++;
            $display("FAIL jump_setup got p4 %h want 10", bus.pcplus4_o);
        end
        bus.jump_i = 1;
        bus.jump_index_i = 26'h12;
        tick();
        checks++;
        if (bus.imem_addr_o !== 6'd18 || m_pc !== 32'h48) begin
            errors++;
            $display("FAIL jump_pc got a%0d want 18", bus.imem_addr_o);
        end
        bus.branch_taken_i = 1;
        bus.branch_target_i = 32'h20;
        tick();
        clear_ctrl();
        checks++;
        if (bus.imem_addr_o !== 6'd8 || bus.valid_o !== 0) begin
            errors++;
            $display("FAIL branch_over_jump got a%0d v%b want 8/0", bus.imem_addr_o, bus.valid_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 32'h20 || bus.instr_o !== imem[8]) begin
            errors++;
            $display("FAIL branch_over_jump_fetch got pc%h want 20", bus.pc_o);
        end
    endtask

    task automatic test_misalign();
        checks++;
        if (bus.misalign_o !== 0) begin
            errors++;
            $display("FAIL misalign_pre got %b want 0", bus.misalign_o);
        end
        bus.branch_taken_i = 1;
        bus.branch_target_i = 32'h22;
        tick();
        checks++;
        if (bus.imem_addr_o !== 6'd8 || bus.misalign_o !== 1) begin
            errors++;
            $display("FAIL misalign_set got a%0d m%b want 8/1", bus.imem_addr_o, bus.misalign_o);
        end
        bus.branch_target_i = 32'h40;
        tick();
        clear_ctrl();
        tick();
        checks++;
        if (bus.misalign_o !== 1 || bus.pc_o !== 32'h40) begin
            errors++;
            $display("FAIL misalign_sticky got m%b pc%h want 1/40", bus.misalign_o, bus.pc_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            bus.stall_i = ($urandom_range(0, 3) == 0);
            bus.flush_i = ($urandom_range(0, 5) == 0);
            bus.branch_taken_i = ($urandom_range(0, 7) == 0);
            bus.branch_target_i = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_00FC);
            bus.jump_i = ($urandom_range(0, 7) == 0);
            bus.jump_index_i = 26'($urandom);
            tick();
            checks++;
            if (bus.imem_addr_o !== 6'((m_pc / 4) % 64)) begin
                errors++;
                $display("FAIL rand_addr cyc %0d got %0d want %0d", i, bus.imem_addr_o, (m_pc / 4) % 64);
            end
            checks++;
            if (bus.pc_o !== m_pco || bus.pcplus4_o !== m_p4) begin
                errors++;
                $display("FAIL rand_pc cyc %0d got %h/%h want %h/%h", i, bus.pc_o, bus.pcplus4_o, m_pco, m_p4);
            end
            checks++;
            if (bus.instr_o !== m_instr || bus.valid_o !== m_valid) begin
                errors++;
                $display("FAIL rand_instr cyc %0d got %h/%b want %h/%b", i, bus.instr_o, bus.valid_o, m_instr, m_valid);
            end
            checks++;
            if (bus.misalign_o !== m_mis || bus.fetch_count_o !== m_cnt) begin
                errors++;
                $display("FAIL rand_stat cyc %0d got %b/%0d want %b/%0d", i, bus.misalign_o, bus.fetch_count_o, m_mis, m_cnt);
            end
        end
        reset = 0;
        clear_ctrl();
    endtask

    task automatic test_wrap_reset();
        tick();
        checks++;
        if (bus2.imem_addr_o !== 6'd63 || bus2.valid_o !== 0) begin
            errors++;
            $display("FAIL wrap_reset got a%0d v%b want 63/0", bus2.imem_addr_o, bus2.valid_o);
        end
        reset2 = 0;
        tick();
        checks++;
        if (bus2.imem_addr_o !== 6'd0 || bus2.pc_o !== 32'hFFFF_FFFC || bus2.pcplus4_o !== 0) begin
            errors++;
            $display("FAIL wrap_pc got a%0d pc%h p4%h want 0/fffffffc/0", bus2.imem_addr_o, bus2.pc_o, bus2.pcplus4_o);
        end
        checks++;
        if (bus2.instr_o !== imem[63]) begin
            errors++;
            $display("FAIL wrap_instr got %h want %h", bus2.instr_o, imem[63]);
        end
        tick();
        checks++;
        if (bus2.pc_o !== 0 || bus2.instr_o !== imem[0]) begin
            errors++;
            $display("FAIL wrap_next got pc%h want 0", bus2.pc_o);
        end
        bus.branch_taken_i = 1;
        bus.branch_target_i = 32'h0000_0023;
        tick();
        bus.stall_i = 1;
        bus.branch_target_i = 32'h0000_0054;
        reset = 1;
        tick();
        reset = 0;
        clear_ctrl();
        checks++;
        if (bus.pc_o !== 0 || bus.pcplus4_o !== 0 || bus.instr_o !== 0 || bus.valid_o !== 0) begin
            errors++;
            $display("FAIL midreset_ifid got %h/%h/%h/%b want 0", bus.pc_o, bus.pcplus4_o, bus.instr_o, bus.valid_o);
        end
        checks++;
        if (bus.misalign_o !== 0 || bus.fetch_count_o !== 0 || bus.imem_addr_o !== 0) begin
            errors++;
            $display("FAIL midreset_state got m%b c%0d a%0d want 0", bus.misalign_o, bus.fetch_count_o, bus.imem_addr_o);
        end
        tick();
        checks++;
        if (bus.pc_o !== 0 || bus.instr_o !== imem[0] || bus.fetch_count_o !== 1) begin
            errors++;
            $display("FAIL midreset_resume got pc%h c%0d want 0/1", bus.pc_o, bus.fetch_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_freerun();
        test_stall();
        test_branch();
        test_jump();
        test_misalign();
        test_random();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
